// File: rtl/wb_load_queue_pkg.sv
// Shared definitions for the write-back load queue: load op encoding,
// queue entry layout and a constant-width helper.
package wb_load_queue_pkg;

  typedef enum logic [2:0] {
    OP_LB  = 3'd0,
    OP_LBU = 3'd1,
    OP_LH  = 3'd2,
    OP_LHU = 3'd3,
    OP_LW  = 3'd4,
    OP_LWL = 3'd5,
    OP_LWR = 3'd6,
    OP_RSV = 3'd7
  } load_op_e;

  // Entry fields are sized for the widest legal configuration; narrower
  // instances zero-extend on write and slice on read.
  localparam int unsigned MAX_DW   = 64;
  localparam int unsigned MAX_OFFW = 3;
  localparam int unsigned MAX_RW   = 16;

  typedef struct packed {
    load_op_e              op;
    logic [MAX_OFFW-1:0]   off;
    logic [MAX_RW-1:0]     wreg;
    logic [MAX_DW-1:0]     rtold;
    logic                  kill;
  } entry_t;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < v) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/wb_load_queue_load_formatter.sv
// Combinational load formatter: selects the addressed word lane, extracts
// and extends bytes/halfwords, merges LWL/LWR with the old rt value and
// flags misaligned halfword/word accesses.
module wb_load_queue_load_formatter
  import wb_load_queue_pkg::*;
#(
  parameter  int DW = 32,
  localparam int OW = clog2(DW / 8)
) (
  input  logic [2:0]    op,
  input  logic [OW-1:0] off,
  input  logic [DW-1:0] rsp_data,
  input  logic [DW-1:0] rtold,
  output logic [DW-1:0] wdata,
  output logic          misalign
);

  logic [31:0] m;
  logic [31:0] o;
  logic [31:0] w;
  logic [1:0]  k;
  logic        bypass;
  logic [7:0]  b;
  logic [15:0] h;

  assign k = off[1:0];

  if (DW == 64) begin : g_lane64
    assign m = off[2] ? rsp_data[63:32] : rsp_data[31:0];
    assign o = off[2] ? rtold[63:32]    : rtold[31:0];
    // Upper bits follow bit 31 of the formatted word; unsigned forms
    // already carry a zero there.
    assign wdata = bypass ? rsp_data : {{32{w[31]}}, w};
  end else begin : g_lane32
    assign m = rsp_data;
    assign o = rtold;
    assign wdata = bypass ? rsp_data : w;
  end

  assign b = m[{k, 3'b000} +: 8];
  assign h = m[{k[1], 4'b0000} +: 16];

  // Format the selected 32-bit lane according to the load op.
  always_comb begin
    w        = '0;
    misalign = 1'b0;
    bypass   = 1'b0;
    case (load_op_e'(op))
      OP_LB:  w = {{24{b[7]}}, b};
      OP_LBU: w = {24'd0, b};
      OP_LH: begin
        if (k[0]) misalign = 1'b1;
        else      w = {{16{h[15]}}, h};
      end
      OP_LHU: begin
        if (k[0]) misalign = 1'b1;
        else      w = {16'd0, h};
      end
      OP_LW: begin
        if (k != 2'd0) misalign = 1'b1;
        else           w = m;
      end
      OP_LWL: begin
        case (k)
          2'd0:    w = {m[7:0],  o[23:0]};
          2'd1:    w = {m[15:0], o[15:0]};
          2'd2:    w = {m[23:0], o[7:0]};
          default: w = m;
        endcase
      end
      OP_LWR: begin
        case (k)
          2'd0:    w = m;
          2'd1:    w = {o[31:24], m[31:8]};
          2'd2:    w = {o[31:16], m[31:16]};
          default: w = {o[31:8],  m[31:24]};
        endcase
      end
      default: bypass = 1'b1;
    endcase
  end

endmodule

// File: rtl/wb_load_queue.sv
// Outstanding-load queue: records loads from the MEM stage, pairs them with
// in-order memory responses and registers the formatted write-back.
module wb_load_queue
  import wb_load_queue_pkg::*;
#(
  parameter  int DW    = 32,
  parameter  int DEPTH = 4,
  parameter  int RW    = 5,
  localparam int OW    = clog2(DW / 8)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [2:0]    req_op,
  input  logic [OW-1:0] req_off,
  input  logic [RW-1:0] req_wreg,
  input  logic [DW-1:0] req_rtold,
  input  logic          flush,
  input  logic          rsp_valid,
  input  logic [DW-1:0] rsp_data,
  output logic          wb_valid,
  output logic [RW-1:0] wb_wreg,
  output logic [DW-1:0] wb_wdata,
  output logic          wb_misalign,
  output logic          rsp_err,
  output logic          stallreq
);

  localparam int PW = clog2(DEPTH);
  localparam int CW = clog2(DEPTH + 1);

  entry_t        q [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  entry_t        head;
  logic          push;
  logic          pop;
  logic [DW-1:0] f_wdata;
  logic          f_misalign;
  logic          unused_entry_bits;

  assign req_ready = (count < CW'(DEPTH));
  assign stallreq  = req_valid && !req_ready;
  assign push      = req_valid && req_ready;
  assign pop       = rsp_valid && (count != '0);
  assign head      = q[rd_ptr];

  // Bits beyond this instance's widths are never read.
  assign unused_entry_bits = ^{head.off, head.wreg, head.rtold};

  wb_load_queue_load_formatter #(.DW(DW)) u_load_formatter (
    .op       (head.op),
    .off      (head.off[OW-1:0]),
    .rsp_data (rsp_data),
    .rtold    (head.rtold[DW-1:0]),
    .wdata    (f_wdata),
    .misalign (f_misalign)
  );

  // Queue pointers, entry storage and registered write-back outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      wb_valid    <= 1'b0;
      wb_misalign <= 1'b0;
      wb_wreg     <= '0;
      wb_wdata    <= '0;
      rsp_err     <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) q[i].kill <= 1'b0;
    end else begin
      // Killing free slots too is harmless: a push always writes kill=0,
      // and this later push assignment wins for the slot it fills.
      if (flush) begin
        for (int unsigned i = 0; i < DEPTH; i++) q[i].kill <= 1'b1;
      end
      if (push) begin
        q[wr_ptr] <= '{op:    load_op_e'(req_op),
                       off:   MAX_OFFW'(req_off),
                       wreg:  MAX_RW'(req_wreg),
                       rtold: MAX_DW'(req_rtold),
                       kill:  1'b0};
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      // The head's kill bit is sampled before any same-cycle flush lands.
      wb_valid    <= pop && !head.kill;
      wb_misalign <= pop && !head.kill && f_misalign;
      if (pop && !head.kill) begin
        wb_wreg  <= head.wreg[RW-1:0];
        wb_wdata <= f_wdata;
      end
      rsp_err <= rsp_valid && (count == '0);
    end
  end

endmodule

// File: tb/tb_wb_load_queue.sv
// Bench for wb_load_queue: table vectors, directed corner sequences and a
// randomized run against a queue-based reference model.
module tb_wb_load_queue;
  import wb_load_queue_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: DW=32
  logic        a_rst, a_req_valid, a_req_ready, a_flush, a_rsp_valid;
  logic        a_wb_valid, a_wb_misalign, a_rsp_err, a_stallreq;
  logic [2:0]  a_req_op;
  logic [1:0]  a_req_off;
  logic [4:0]  a_req_wreg, a_wb_wreg;
  logic [31:0] a_req_rtold, a_rsp_data, a_wb_wdata;

  // Instance B: DW=64
  logic        b_rst, b_req_valid, b_req_ready, b_flush, b_rsp_valid;
  logic        b_wb_valid, b_wb_misalign, b_rsp_err, b_stallreq;
  logic [2:0]  b_req_op;
  logic [2:0]  b_req_off;
  logic [4:0]  b_req_wreg, b_wb_wreg;
  logic [63:0] b_req_rtold, b_rsp_data, b_wb_wdata;

  wb_load_queue #(.DW(32), .DEPTH(4), .RW(5)) dut_a (
    .clk(clk), .rst(a_rst), .req_valid(a_req_valid), .req_ready(a_req_ready),
    .req_op(a_req_op), .req_off(a_req_off), .req_wreg(a_req_wreg),
    .req_rtold(a_req_rtold), .flush(a_flush), .rsp_valid(a_rsp_valid),
    .rsp_data(a_rsp_data), .wb_valid(a_wb_valid), .wb_wreg(a_wb_wreg),
    .wb_wdata(a_wb_wdata), .wb_misalign(a_wb_misalign), .rsp_err(a_rsp_err),
    .stallreq(a_stallreq)
  );

  wb_load_queue #(.DW(64), .DEPTH(4), .RW(5)) dut_b (
    .clk(clk), .rst(b_rst), .req_valid(b_req_valid), .req_ready(b_req_ready),
    .req_op(b_req_op), .req_off(b_req_off), .req_wreg(b_req_wreg),
    .req_rtold(b_req_rtold), .flush(b_flush), .rsp_valid(b_rsp_valid),
    .rsp_data(b_rsp_data), .wb_valid(b_wb_valid), .wb_wreg(b_wb_wreg),
    .wb_wdata(b_wb_wdata), .wb_misalign(b_wb_misalign), .rsp_err(b_rsp_err),
    .stallreq(b_stallreq)
  );

  int unsigned total  = 0;
  int unsigned passed = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
  endtask

  // Reference formatter written from the load rules with shifts and masks.
  function automatic logic [63:0] ref_fmt(input int dw, input logic [2:0] op,
                                          input logic [2:0] off, input logic [63:0] data,
                                          input logic [63:0] rtold, output logic mis);
    logic [31:0] m, o, w;
    logic [63:0] res;
    int k, sh;
    mis = 1'b0;
    if (dw == 64 && off[2]) begin m = data[63:32]; o = rtold[63:32]; end
    else begin m = data[31:0]; o = rtold[31:0]; end
    k = int'(off[1:0]);
    w = 32'd0;
    case (op)
      3'd0, 3'd1: begin
        w = (m >> (8 * k)) & 32'hFF;
        if (op == 3'd0 && w >= 32'd128) w = w - 32'd256;
      end
      3'd2, 3'd3: begin
        if (k % 2 != 0) mis = 1'b1;
        else begin
          w = (m >> (8 * k)) & 32'hFFFF;
          if (op == 3'd2 && w >= 32'd32768) w = w - 32'd65536;
        end
      end
      3'd4: if (k != 0) mis = 1'b1; else w = m;
      3'd5: begin
        sh = 8 * (3 - k);
        w = (m << sh) | (o & ((32'd1 << sh) - 32'd1));
      end
      3'd6: begin
        sh = 8 * k;
        w = (m >> sh) | (o & ~(32'hFFFF_FFFF >> sh));
      end
      default: begin
        if (dw == 32) return {32'd0, data[31:0]};
        return data;
      end
    endcase
    res = {{32{w[31]}}, w};
    if (dw == 32) res[63:32] = 32'd0;
    return res;
  endfunction

  task automatic a_idle();
    a_req_valid = 0; a_flush = 0; a_rsp_valid = 0;
    a_req_op = 0; a_req_off = 0; a_req_wreg = 0; a_req_rtold = 0; a_rsp_data = 0;
  endtask

  task automatic b_idle();
    b_req_valid = 0; b_flush = 0; b_rsp_valid = 0;
    b_req_op = 0; b_req_off = 0; b_req_wreg = 0; b_req_rtold = 0; b_rsp_data = 0;
  endtask

  // Push one load, return its response one cycle later; ends where wb is visible.
  task automatic a_load(input logic [2:0] op, input logic [1:0] off, input logic [4:0] wreg,
                        input logic [31:0] rtold, input logic [31:0] data);
    a_req_valid = 1; a_req_op = op; a_req_off = off; a_req_wreg = wreg; a_req_rtold = rtold;
    @(negedge clk);
    a_req_valid = 0; a_rsp_valid = 1; a_rsp_data = data;
    @(negedge clk);
    a_rsp_valid = 0;
  endtask

  task automatic b_load(input logic [2:0] op, input logic [2:0] off, input logic [4:0] wreg,
                        input logic [63:0] rtold, input logic [63:0] data);
    b_req_valid = 1; b_req_op = op; b_req_off = off; b_req_wreg = wreg; b_req_rtold = rtold;
    @(negedge clk);
    b_req_valid = 0; b_rsp_valid = 1; b_rsp_data = data;
    @(negedge clk);
    b_rsp_valid = 0;
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [1:0]  off;
    logic [31:0] rtold;
    logic [31:0] data;
    logic [31:0] wdata;
    logic        mis;
  } vec_t;

  typedef struct {
    logic [2:0]  op;
    logic [2:0]  off;
    logic [63:0] rtold;
    logic [63:0] data;
    logic [63:0] wdata;
  } vec64_t;

  typedef struct {
    logic [2:0]  op;
    logic [1:0]  off;
    logic [4:0]  wreg;
    logic [31:0] rtold;
    bit          kill;
  } ment_t;

  vec_t   tbl [13];
  vec64_t tbl64 [4];
  ment_t  mq [$];

  initial begin
    logic        e_valid, e_err, e_mis, push, pop;
    logic [4:0]  e_wreg;
    logic [31:0] e_wdata;
    logic [63:0] r;
    ment_t       hd;

    tbl[0]  = '{3'd0, 2'd1, 32'h0,         32'h0000_8000, 32'hFFFF_FF80, 1'b0};
    tbl[1]  = '{3'd1, 2'd1, 32'h0,         32'h0000_8000, 32'h0000_0080, 1'b0};
    tbl[2]  = '{3'd2, 2'd2, 32'h0,         32'h8001_0000, 32'hFFFF_8001, 1'b0};
    tbl[3]  = '{3'd3, 2'd2, 32'h0,         32'h8001_0000, 32'h0000_8001, 1'b0};
    tbl[4]  = '{3'd4, 2'd0, 32'h0,         32'h1234_5678, 32'h1234_5678, 1'b0};
    tbl[5]  = '{3'd2, 2'd1, 32'h0,         32'h1234_5678, 32'h0000_0000, 1'b1};
    tbl[6]  = '{3'd4, 2'd2, 32'h0,         32'h1234_5678, 32'h0000_0000, 1'b1};
    tbl[7]  = '{3'd5, 2'd1, 32'hAABB_CCDD, 32'h1122_3344, 32'h3344_CCDD, 1'b0};
    tbl[8]  = '{3'd6, 2'd2, 32'hAABB_CCDD, 32'h1122_3344, 32'hAABB_1122, 1'b0};
    tbl[9]  = '{3'd5, 2'd0, 32'hAABB_CCDD, 32'h1122_3344, 32'h44BB_CCDD, 1'b0};
    tbl[10] = '{3'd6, 2'd3, 32'hAABB_CCDD, 32'h1122_3344, 32'hAABB_CC11, 1'b0};
    tbl[11] = '{3'd7, 2'd3, 32'h0,         32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0};
    tbl[12] = '{3'd0, 2'd3, 32'h0,         32'h7F00_0000, 32'h0000_007F, 1'b0};

    tbl64[0] = '{3'd4, 3'd4, 64'h0, 64'h8765_4321_0000_0000, 64'hFFFF_FFFF_8765_4321};
    tbl64[1] = '{3'd6, 3'd6, 64'h1111_2222_AABB_CCDD, 64'h8765_4321_0000_0000,
                 64'h0000_0000_1111_8765};
    tbl64[2] = '{3'd0, 3'd7, 64'h0, 64'h8765_4321_0000_0000, 64'hFFFF_FFFF_FFFF_FF87};
    tbl64[3] = '{3'd7, 3'd1, 64'h0, 64'h8765_4321_0BAD_F00D, 64'h8765_4321_0BAD_F00D};

    a_idle(); b_idle();
    a_rst = 1; b_rst = 1;
    repeat (2) @(negedge clk);
    a_rst = 0; b_rst = 0;

    check("rst_wb_valid", a_wb_valid, 0);
    check("rst_wb_wdata", a_wb_wdata, 0);
    check("rst_wb_wreg", a_wb_wreg, 0);
    check("rst_wb_misalign", a_wb_misalign, 0);
    check("rst_rsp_err", a_rsp_err, 0);
    check("rst_req_ready", a_req_ready, 1);
    check("rst_b_wb_valid", b_wb_valid, 0);

    // Table vectors on the 32-bit instance
    for (int i = 0; i < 13; i++) begin
      a_load(tbl[i].op, tbl[i].off, 5'(i + 1), tbl[i].rtold, tbl[i].data);
      check($sformatf("tbl%0d_valid", i), a_wb_valid, 1);
      check($sformatf("tbl%0d_wreg", i), a_wb_wreg, 5'(i + 1));
      check($sformatf("tbl%0d_wdata", i), a_wb_wdata, tbl[i].wdata);
      check($sformatf("tbl%0d_misalign", i), a_wb_misalign, tbl[i].mis);
    end
    @(negedge clk);
    check("wb_valid_one_cycle", a_wb_valid, 0);

    // Fill to DEPTH, stall, then drain in order
    a_req_valid = 1; a_req_op = 3'd4; a_req_off = 0;
    for (int i = 0; i < 4; i++) begin
      a_req_wreg = 5'(10 + i);
      @(negedge clk);
    end
    a_req_wreg = 5'd20;
    #1;
    check("full_req_ready", a_req_ready, 0);
    check("full_stallreq", a_stallreq, 1);
    @(negedge clk);
    check("full_no_push_ready", a_req_ready, 0);
    a_req_valid = 0; a_rsp_valid = 1; a_rsp_data = 32'h5;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i == 0) check("ready_after_pop", a_req_ready, 1);
      check($sformatf("drain%0d_valid", i), a_wb_valid, 1);
      check($sformatf("drain%0d_wreg", i), a_wb_wreg, 5'(10 + i));
    end
    a_rsp_valid = 0;
    @(negedge clk);
    check("drain_done_valid", a_wb_valid, 0);
    check("drain_empty_ready", a_req_ready, 1);

    // Flush kills queued loads but not the load pushed in the flush cycle
    a_req_valid = 1; a_req_op = 3'd4; a_req_off = 0;
    for (int i = 0; i < 3; i++) begin
      a_req_wreg = 5'(1 + i);
      @(negedge clk);
    end
    a_flush = 1; a_req_wreg = 5'd4;
    @(negedge clk);
    a_flush = 0; a_req_valid = 0; a_rsp_valid = 1; a_rsp_data = 32'h77;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("flush%0d_valid", i), a_wb_valid, (i == 3));
      if (i == 3) check("flush_post_wreg", a_wb_wreg, 5'd4);
    end
    a_rsp_valid = 0;
    @(negedge clk);

    // Pop in the flush cycle still writes back
    a_req_valid = 1; a_req_wreg = 5'd7;
    @(negedge clk);
    a_req_valid = 0; a_rsp_valid = 1; a_flush = 1; a_rsp_data = 32'h99;
    @(negedge clk);
    a_rsp_valid = 0; a_flush = 0;
    check("flush_pop_valid", a_wb_valid, 1);
    check("flush_pop_wreg", a_wb_wreg, 5'd7);

    // Response with nothing outstanding
    @(negedge clk);
    a_rsp_valid = 1;
    @(negedge clk);
    a_rsp_valid = 0;
    check("empty_rsp_err", a_rsp_err, 1);
    check("empty_rsp_no_wb", a_wb_valid, 0);
    @(negedge clk);
    check("rsp_err_pulse", a_rsp_err, 0);

    // 64-bit instance vectors
    for (int i = 0; i < 4; i++) begin
      b_load(tbl64[i].op, tbl64[i].off, 5'(i + 3), tbl64[i].rtold, tbl64[i].data);
      check($sformatf("b%0d_valid", i), b_wb_valid, 1);
      check($sformatf("b%0d_wreg", i), b_wb_wreg, 5'(i + 3));
      check($sformatf("b%0d_wdata", i), b_wb_wdata, tbl64[i].wdata);
    end

    // Reset in the middle of a burst
    b_req_valid = 1; b_req_op = 3'd4; b_req_off = 0; b_req_wreg = 5'd9;
    repeat (2) @(negedge clk);
    b_req_valid = 0; b_rsp_valid = 1; b_rsp_data = 64'h1234;
    @(negedge clk);
    check("b_burst_valid", b_wb_valid, 1);
    b_rst = 1;
    @(negedge clk);
    b_rst = 0;
    check("b_rst_wb_valid", b_wb_valid, 0);
    check("b_rst_wb_wdata", b_wb_wdata, 0);
    check("b_rst_wb_wreg", b_wb_wreg, 0);
    check("b_rst_ready", b_req_ready, 1);
    @(negedge clk);
    b_rsp_valid = 0;
    check("b_rst_rsp_err", b_rsp_err, 1);
    check("b_rst_no_wb", b_wb_valid, 0);

    // Randomized run against the reference model
    a_idle();
    a_rst = 1;
    @(negedge clk);
    a_rst = 0;
    mq.delete();
    e_valid = 0; e_err = 0; e_mis = 0; e_wreg = 0; e_wdata = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      check("rnd_wb_valid", a_wb_valid, e_valid);
      check("rnd_rsp_err", a_rsp_err, e_err);
      check("rnd_misalign", a_wb_misalign, e_mis);
      if (e_valid) begin
        check("rnd_wreg", a_wb_wreg, e_wreg);
        check("rnd_wdata", a_wb_wdata, e_wdata);
      end
      a_rst       = ($urandom_range(0, 499) == 0);
      a_req_valid = 1'($urandom_range(0, 1));
      a_req_op    = 3'($urandom_range(0, 7));
      a_req_off   = 2'($urandom_range(0, 3));
      a_req_wreg  = 5'($urandom_range(0, 31));
      a_req_rtold = $urandom;
      a_flush     = ($urandom_range(0, 19) == 0);
      a_rsp_valid = (mq.size() != 0) ? ($urandom_range(0, 2) != 0)
                                     : ($urandom_range(0, 9) == 0);
      a_rsp_data  = $urandom;
      #1;
      check("rnd_req_ready", a_req_ready, (mq.size() < 4));
      check("rnd_stallreq", a_stallreq, a_req_valid && (mq.size() >= 4));
      if (a_rst) begin
        mq.delete();
        e_valid = 0; e_err = 0; e_mis = 0;
      end else begin
        push    = a_req_valid && (mq.size() < 4);
        pop     = a_rsp_valid && (mq.size() != 0);
        e_err   = a_rsp_valid && (mq.size() == 0);
        e_valid = 0; e_mis = 0;
        if (pop) begin
          hd = mq.pop_front();
          if (!hd.kill) begin
            e_valid = 1;
            e_wreg  = hd.wreg;
            r = ref_fmt(32, hd.op, {1'b0, hd.off}, {32'd0, a_rsp_data},
                        {32'd0, hd.rtold}, e_mis);
            e_wdata = r[31:0];
          end
        end
        if (a_flush) foreach (mq[i]) mq[i].kill = 1;
        if (push) mq.push_back('{a_req_op, a_req_off, a_req_wreg, a_req_rtold, 1'b0});
      end
      @(negedge clk);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
